// File: rtl/my_softcore_pio_ext.sv
// Avalon-MM parallel I/O port with data, direction and atomic set/clear output access.
// Defining MY_SOFTCORE_PIO_EXT_IRQ_EN adds edge capture, interrupt mask and the irq output.
module my_softcore_pio_ext #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);

  logic                  wrEn;
  logic [DATA_WIDTH-1:0] wrData;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] s1_q, s2_q;
  logic [DATA_WIDTH-1:0] readNarrow;
  logic [31:0]           readdata_q, readdata_d;

  assign wrEn   = chipselect & ~write_n;
  assign wrData = writedata[DATA_WIDTH-1:0];

`ifdef MY_SOFTCORE_PIO_EXT_IRQ_EN
  logic [DATA_WIDTH-1:0] s3_q;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] capture_q, capture_d;
  logic [DATA_WIDTH-1:0] edgeDet, w1c;
  logic                  irq_q, irq_d;

  always_comb begin
    case (EDGE_TYPE)
      0:       edgeDet = s2_q & ~s3_q;
      1:       edgeDet = ~s2_q & s3_q;
      default: edgeDet = s2_q ^ s3_q;
    endcase
  end

  // A fresh edge is OR-ed in after the clear so it wins over a simultaneous W1C.
  always_comb begin
    mask_d = mask_q;
    if (wrEn && address == 3'd2) mask_d = wrData;
    w1c       = (wrEn && address == 3'd3) ? wrData : '0;
    capture_d = (capture_q & ~w1c) | edgeDet;
    irq_d     = |(capture_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_q      <= '0;
      mask_q    <= '0;
      capture_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      s3_q      <= s2_q;
      mask_q    <= mask_d;
      capture_q <= capture_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unusedEdgeType;
  assign unusedEdgeType = (EDGE_TYPE != 0);
  assign irq = 1'b0;
`endif

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    if (wrEn) begin
      case (address)
        3'd0:    data_d = wrData;
        3'd1:    dir_d  = wrData;
        3'd4:    data_d = data_q | wrData;
        3'd5:    data_d = data_q & ~wrData;
        default: ;
      endcase
    end
  end

  // Read data is registered every cycle whether or not the slave is selected.
  always_comb begin
    readNarrow = '0;
    case (address)
      3'd0:    readNarrow = s2_q;
      3'd1:    readNarrow = dir_q;
`ifdef MY_SOFTCORE_PIO_EXT_IRQ_EN
      3'd2:    readNarrow = mask_q;
      3'd3:    readNarrow = capture_q;
`endif
      default: ;
    endcase
    readdata_d = 32'(readNarrow);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      dir_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      dir_q      <= dir_d;
      s1_q       <= in_port;
      s2_q       <= s1_q;
      readdata_q <= readdata_d;
    end
  end

  assign out_port = data_q;
  assign oe       = dir_q;
  assign readdata = readdata_q;

endmodule
